// File: rtl/sha_msg_schedule_stream.sv
// SHA-256/512 message schedule: loads a 16-word block on start, then streams W[0..ROUNDS-1].
// One word per cycle; w_valid holds and the window freezes while w_ready is low. Start to done is ROUNDS+1 cycles.
module sha_msg_schedule_stream #(
   parameter  int MODE   = 0,
   localparam int WORD_W = (MODE == 0) ? 32 : 64,
   localparam int ROUNDS = (MODE == 0) ? 64 : 80,
   localparam int TW     = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [16*WORD_W-1:0]  i_block_in,
   output logic                  o_busy,
   output logic                  o_w_valid,
   input  logic                  i_w_ready,
   output logic [WORD_W-1:0]     o_w_out,
   output logic [TW-1:0]         o_t_idx,
   output logic                  o_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WORD_W-1:0]   r_win [16];
   logic [TW-1:0]       r_t_idx;
   logic [WORD_W-1:0]   w_new;
   logic                w_xfer;
   logic                w_last;

   function automatic logic [WORD_W-1:0] f_rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] f_sigma0(input logic [WORD_W-1:0] x);
      if (MODE == 0) return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
      else           return f_rotr(x, 1) ^ f_rotr(x, 8)  ^ (x >> 7);
   endfunction

   function automatic logic [WORD_W-1:0] f_sigma1(input logic [WORD_W-1:0] x);
      if (MODE == 0) return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
      else           return f_rotr(x, 19) ^ f_rotr(x, 61) ^ (x >> 6);
   endfunction

   // Window slot 15 receives W[t+16]; values computed past ROUNDS-1 are never emitted.
   assign w_new  = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];
   assign w_xfer = (r_state == S_RUN) && i_w_ready;
   assign w_last = (r_t_idx == TW'(ROUNDS - 1));

   always_comb begin
      w_state_nxt = r_state;
      o_w_valid   = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_w_valid = 1'b1;
            o_busy    = 1'b1;
            if (w_xfer && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_t_idx <= '0;
         for (int k = 0; k < 16; k++) r_win[k] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && i_start) begin
            r_t_idx <= '0;
            for (int k = 0; k < 16; k++) r_win[k] <= i_block_in[(16-k)*WORD_W-1 -: WORD_W];
         end else if (w_xfer) begin
            r_t_idx <= w_last ? '0 : r_t_idx + TW'(1);
            for (int k = 0; k < 15; k++) r_win[k] <= r_win[k+1];
            r_win[15] <= w_new;
         end else if (r_state == S_DONE) begin
            r_t_idx <= '0;
         end
      end
   end

   assign o_w_out = r_win[0];
   assign o_t_idx = r_t_idx;

endmodule

// File: doc/sha_msg_schedule_stream.md
Name: sha_msg_schedule_stream

Overview:
- Parametrised SHA-2 message-schedule generator, replacing the fixed 32-bit, count-driven expansion controller.
- Sequence: captures one 16-word message block, then streams W[0..ROUNDS-1] to the compression round datapath over a valid/ready handshake. Each word is produced in one cycle.
- W[16..] is computed internally with a 16-word shift window and the sigma functions. No external adder or RAM round-trip is needed.
- Compile-time mode selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds).

Parameters:
- MODE, 0, 0 = SHA-256, 1 = SHA-512.
- WORD_W, derived localparam: 32 when MODE=0, 64 when MODE=1.
- ROUNDS, derived localparam: 64 when MODE=0, 80 when MODE=1.
- TW, derived localparam, 7: width of t_idx.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to load block_in; honoured only in IDLE.
- block_in  in  16*WORD_W  message block; word 0 is the MSB slice, block_in[16*WORD_W-1 -: WORD_W].
- busy  out  1  high from the cycle after an accepted start until done.
- w_valid  out  1  w_out holds a valid schedule word.
- w_ready  in  1  consumer accepts w_out this cycle.
- w_out  out  WORD_W  current schedule word W[t_idx].
- t_idx  out  TW  index t of w_out.
- done  out  1  one-cycle pulse after W[ROUNDS-1] is accepted.

Behaviour:
- Reset:
  - Everything is synchronous to clk; rst dominates all other inputs.
  - Values after rst: state=IDLE, window words=0, busy=0, w_valid=0, w_out=0, t_idx=0, done=0.
  - rst mid-stream aborts the stream; there is no done pulse and no partial output afterwards.
- States:
  - IDLE: waits for start.
  - RUN: streams words.
  - DONE: single cycle, returns to IDLE.
- IDLE, start=1 at cycle N:
  - Load window win[k] = block word k, for k = 0..15.
  - Set t_idx=0 and enter RUN.
  - At N+1: w_valid=1, busy=1, w_out=win[0]=W[0].
  - start=1 in RUN or DONE is ignored.
- Output: w_out is always win[0]. It is a registered output with no combinational path from w_ready.
- Transfer = w_valid & w_ready. On each transfer:
  - Shift the window: win[k] <= win[k+1] for k = 0..14.
  - win[15] <= new, where new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^WORD_W.
  - This produces W[t+16] from W[t+14], W[t+9], W[t+1] and W[t].
  - t_idx increments by 1.
  - Computing new for t+16 >= ROUNDS is harmless; those values are never emitted.
- Stall: w_ready=0 holds window, t_idx and w_valid unchanged. Stalls of any length are allowed, including stalls on t_idx=0 and on t_idx=ROUNDS-1.
- Last word: a transfer with t_idx=ROUNDS-1 moves to DONE.
  - DONE cycle: w_valid=0, done=1, busy=0, t_idx reset to 0.
  - Next cycle: IDLE. A start asserted in the DONE cycle is ignored; a new start is accepted from IDLE only, giving 1 dead cycle minimum between blocks.
- MODE=0 functions (32-bit):
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10.
- MODE=1 functions (64-bit):
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7.
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6.
- Arithmetic: all additions are unsigned, WORD_W bits, carries discarded.
- Throughput: ROUNDS words in ROUNDS cycles when w_ready is held high.
- Block latency: start to done = ROUNDS+1 cycles.
- block_in is sampled only in the start cycle; later changes have no effect.

Test Plan:
- MODE=0, "abc" block (word0=0x61626380, words 1..14=0, word15=0x00000018), w_ready=1 -> stream:
  - W[0]=0x61626380, W[15]=0x00000018.
  - W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405.
  - Exactly 64 words, then done pulses once at start+65.
- MODE=1, "abc" block (word0=0x6162638000000000, word15=0x18) -> stream:
  - W[16]=0x6162638000000000, W[17]=0x00030000000000C0.
  - Exactly 80 words, then done pulse.
- MODE=0, random block, random w_ready pattern (including 10-cycle stalls at t=0 and t=63) -> accepted sequence matches the reference-model schedule; w_out and t_idx stable while stalled; no word lost or duplicated.
- start pulsed at t_idx=20 and again in the DONE cycle -> both ignored; the stream continues unaltered. A start in the following IDLE cycle loads the new block, and W[0] appears the next cycle.
- rst asserted at t_idx=30 -> next cycle w_valid=0, busy=0, t_idx=0, w_out=0, no done pulse. A following start produces a correct full schedule.
- All-ones block (MODE=0) -> W[16] = sigma1(0xFFFFFFFF)+0xFFFFFFFF+sigma0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32. Checks carry wrap; matches the model.
